ddr2_traffic_gen: RTL and testbench
===================================

Name: ddr2_traffic_gen

Overview:
Self-test traffic generator and read-back checker that sits directly upstream of the DDR2 controller's user burst interface inside top1.
- After the controller reports init_end, it writes a deterministic pattern over NUM_BURSTS bursts.
- It then reads the same region back and compares every word.
- It drives the board LEDs: init done, write phase over, read error.

Parameters:
ADDR_WIDTH, 26, burst address width (ROW 13 + COL 10 + BA 3)
DATA_WIDTH, 32, user data word width (2 x DQ_BITS)
WBURST_LEN, 8, words per write burst (1..255)
RBURST_LEN, 8, words per read burst (1..255)
NUM_BURSTS, 16, bursts per phase (>=1)
WR_DELAY, 200, sys_clk cycles idle between init_end and the first write request
RD_DELAY, 2000, sys_clk cycles idle between the last write finish and the first read request

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst_n  in  1  asynchronous active-low reset
init_end  in  1  controller initialisation complete (level)
wr_burst_req  out  1  write burst request, held until wr_burst_finish
wr_burst_addr  out  ADDR_WIDTH  write burst start address
wr_burst_len  out  8  write burst length (= WBURST_LEN)
wr_burst_data_req  in  1  controller consumes the current wr_burst_data word this cycle
wr_burst_data  out  DATA_WIDTH  current write word
wr_burst_finish  in  1  one-cycle pulse: write burst complete
rd_burst_req  out  1  read burst request, held until rd_burst_finish
rd_burst_addr  out  ADDR_WIDTH  read burst start address
rd_burst_len  out  8  read burst length (= RBURST_LEN)
rd_burst_data_valid  in  1  rd_burst_data valid this cycle
rd_burst_data  in  DATA_WIDTH  read word
rd_burst_finish  in  1  one-cycle pulse: read burst complete
init_end_led  out  1  registered copy of init_end
wr_over_led  out  1  write phase complete (sticky until abort or reset)
rd_error_led  out  1  any mismatch or protocol error seen (sticky until reset)
test_done  out  1  read phase complete
err_count  out  16  mismatching/missing/extra read beats, saturates at 16'hFFFF

Behaviour:
Reset:
- All outputs are 0; FSM is in IDLE.
- Burst, word and delay counters are 0.

FSM: IDLE -> WR_WAIT -> WR_BURST -> RD_WAIT -> RD_BURST -> DONE.
- IDLE: wait for registered init_end = 1, then go to WR_WAIT.
- WR_WAIT: count WR_DELAY cycles. On terminal count, assert wr_burst_req on the next cycle and enter WR_BURST.
- WR_BURST:
  - wr_burst_addr = burst_idx * WBURST_LEN; wr_burst_len = WBURST_LEN. Both are stable while the request is high.
  - The word index k starts at burst_idx * WBURST_LEN. wr_burst_data = k zero-extended/truncated to DATA_WIDTH, registered.
  - Each cycle with wr_burst_data_req = 1 advances k by 1 on the next edge. After WBURST_LEN beats, further data_req beats are ignored and the data is held.
  - On wr_burst_finish: deassert wr_burst_req on the next edge and increment burst_idx. If WBURST_LEN beats were not all taken, the remaining words are skipped and the next burst starts at its own base.
  - Request rule: the request re-asserts one cycle after finish, never in the same cycle as finish.
  - Last burst: after NUM_BURSTS bursts, set wr_over_led, clear burst_idx and enter RD_WAIT.
- RD_WAIT: count RD_DELAY cycles, then assert rd_burst_req and enter RD_BURST.
- RD_BURST:
  - rd_burst_addr = burst_idx * RBURST_LEN; the expected value is the word index, as in the write phase.
  - Each rd_burst_data_valid beat is compared with the expected word, then the expected index advances.
  - Mismatch: err_count +1 and rd_error_led is set.
  - A valid beat beyond RBURST_LEN counts as one error and is not compared.
  - On rd_burst_finish with fewer than RBURST_LEN beats: add the missing count to err_count (saturating) and set rd_error_led.
  - valid and finish in the same cycle: count the beat first, then check the beat total.
  - Last burst: after NUM_BURSTS bursts, enter DONE.
- DONE: test_done = 1; hold all state. The test runs only once per reset.

Abort and reset:
- If init_end falls in any state other than IDLE:
  - requests drop on the next edge and the FSM returns to IDLE;
  - wr_over_led, test_done and all counters except err_count clear;
  - rd_error_led and err_count keep their values;
  - the test restarts when init_end rises again.
- Asserting sys_rst_n low mid-burst clears everything asynchronously.

Other rules:
- All address arithmetic is modulo 2^ADDR_WIDTH.
- The delay counters are wide enough for max(WR_DELAY, RD_DELAY).
- A finish pulse arriving while no request is outstanding is ignored.

Test Plan:
1. Nominal run:
   - Setup: NUM_BURSTS=4, WR_DELAY=20, RD_DELAY=50; ideal responder echoes written memory; init_end rises at cycle 100.
   - First wr_burst_req at cycle ~121 with addr 0, then bursts at addr 8, 16, 24, carrying data 0..31.
   - After the fourth finish, wr_over_led=1 and the first rd_burst_req follows 50 cycles later.
   - Final state: test_done=1, err_count=0, rd_error_led=0.
2. Corrupt read data: responder flips bit 0 of word 13 -> err_count=1, rd_error_led=1, test_done=1.
3. Short read burst: responder returns 6 of 8 beats in burst 2, then finish -> err_count=2, following bursts start at addr 24 and are checked correctly.
4. Extra read beat: responder sends 9 valid beats in burst 0 -> err_count=1; the 9th beat is not compared.
5. Write backpressure: data_req toggles every other cycle -> each wr_burst_data value is held until consumed, and memory holds 0..31.
6. Abort and reset:
   - init_end drops mid write burst 1 -> requests low next cycle; wr_over_led=0; run restarts at addr 0 when init_end returns.
   - sys_rst_n low mid-read -> all outputs 0 immediately.

Source files
------------

// File: rtl/ddr2_traffic_gen.sv
// ddr2_traffic_gen: self-test traffic source and read-back checker for the
// DDR2 controller user burst interface. After controller init it writes an
// address-indexed pattern over NUM_BURSTS bursts, reads the same region back,
// counts every bad, missing or extra read beat, and drives the board LEDs.
module ddr2_traffic_gen #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WBURST_LEN = 8,
  parameter int unsigned RBURST_LEN = 8,
  parameter int unsigned NUM_BURSTS = 16,
  parameter int unsigned WR_DELAY   = 200,
  parameter int unsigned RD_DELAY   = 2000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  init_end,
  output logic                  wr_burst_req,
  output logic [ADDR_WIDTH-1:0] wr_burst_addr,
  output logic [7:0]            wr_burst_len,
  input  logic                  wr_burst_data_req,
  output logic [DATA_WIDTH-1:0] wr_burst_data,
  input  logic                  wr_burst_finish,
  output logic                  rd_burst_req,
  output logic [ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [7:0]            rd_burst_len,
  input  logic                  rd_burst_data_valid,
  input  logic [DATA_WIDTH-1:0] rd_burst_data,
  input  logic                  rd_burst_finish,
  output logic                  init_end_led,
  output logic                  wr_over_led,
  output logic                  rd_error_led,
  output logic                  test_done,
  output logic [15:0]           err_count
);

  localparam int unsigned DLY_MAX  = (WR_DELAY > RD_DELAY) ? WR_DELAY : RD_DELAY;
  localparam int unsigned DLY_W    = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
  // Terminal counts; a zero delay still spends one cycle in the wait state.
  localparam int unsigned WR_TC    = (WR_DELAY > 0) ? WR_DELAY - 1 : 0;
  localparam int unsigned RD_TC    = (RD_DELAY > 0) ? RD_DELAY - 1 : 0;
  localparam int unsigned BIDX_W   = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int unsigned BEAT_MAX = (WBURST_LEN > RBURST_LEN) ? WBURST_LEN : RBURST_LEN;
  localparam int unsigned BEAT_W   = $clog2(BEAT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_BURST,
    RD_WAIT,
    RD_BURST,
    DONE
  } state_t;

  state_t                state;
  logic                  init_end_r;
  logic [DLY_W-1:0]      dly_cnt;
  logic [BIDX_W-1:0]     burst_idx;
  logic [BEAT_W-1:0]     beat_cnt;
  // Word index shared by both phases: next word to send, or next word expected.
  logic [ADDR_WIDTH-1:0] word_idx;

  logic                  last_burst;
  logic                  wr_take;
  logic [ADDR_WIDTH-1:0] wr_next_base;
  logic [ADDR_WIDTH-1:0] rd_next_base;
  logic                  rd_active;
  logic                  rd_beat;
  logic                  rd_in_window;
  logic                  rd_take;
  logic                  rd_beat_err;
  logic [BEAT_W-1:0]     rd_beats_next;
  logic [16:0]           rd_missing;
  logic [16:0]           err_add;
  logic [16:0]           err_sum;
  logic [15:0]           err_next;

  assign init_end_led = init_end_r;
  assign wr_burst_len = wr_burst_req ? 8'(WBURST_LEN) : 8'd0;
  assign rd_burst_len = rd_burst_req ? 8'(RBURST_LEN) : 8'd0;

  assign last_burst   = (burst_idx == BIDX_W'(NUM_BURSTS - 1));
  assign wr_next_base = wr_burst_addr + ADDR_WIDTH'(WBURST_LEN);
  assign rd_next_base = rd_burst_addr + ADDR_WIDTH'(RBURST_LEN);

  // A write beat is taken only inside the burst window; surplus data_req is ignored.
  assign wr_take = (state == WR_BURST) && wr_burst_req && wr_burst_data_req &&
                   (beat_cnt < BEAT_W'(WBURST_LEN));

  assign rd_active     = (state == RD_BURST) && rd_burst_req;
  assign rd_beat       = rd_active && rd_burst_data_valid;
  assign rd_in_window  = (beat_cnt < BEAT_W'(RBURST_LEN));
  assign rd_take       = rd_beat && rd_in_window;
  // Beats past the burst length count as one error each and are never compared.
  assign rd_beat_err   = rd_beat &&
                         (!rd_in_window || (rd_burst_data != DATA_WIDTH'(word_idx)));
  // The beat arriving with finish is counted before the shortfall is measured.
  assign rd_beats_next = beat_cnt + BEAT_W'(rd_take);

  // Error increment for this cycle, saturated at the 16-bit ceiling.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rd_missing = '0;
    if (rd_active && rd_burst_finish) begin
      rd_missing = 17'(RBURST_LEN) - 17'(rd_beats_next);
    end
    err_add  = 17'(rd_beat_err) + rd_missing;
    err_sum  = {1'b0, err_count} + err_add;
    err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // Sequencer: delays, write phase, read-back check, with abort on init_end loss.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      init_end_r    <= 1'b0;
      dly_cnt       <= '0;
      burst_idx     <= '0;
      beat_cnt      <= '0;
      word_idx      <= '0;
      wr_burst_req  <= 1'b0;
      wr_burst_addr <= '0;
      wr_burst_data <= '0;
      rd_burst_req  <= 1'b0;
      rd_burst_addr <= '0;
      wr_over_led   <= 1'b0;
      rd_error_led  <= 1'b0;
      test_done     <= 1'b0;
      err_count     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      init_end_r <= init_end;
      if ((state != IDLE) && !init_end) begin
        // Abort: drop everything but the error history and wait for a new init.
        state         <= IDLE;
        dly_cnt       <= '0;
        burst_idx     <= '0;
        beat_cnt      <= '0;
        word_idx      <= '0;
        wr_burst_req  <= 1'b0;
        wr_burst_addr <= '0;
        wr_burst_data <= '0;
        rd_burst_req  <= 1'b0;
        rd_burst_addr <= '0;
        wr_over_led   <= 1'b0;
        test_done     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (init_end_r) begin
              state   <= WR_WAIT;
              dly_cnt <= '0;
            end
          end

          WR_WAIT: begin
            if (dly_cnt == DLY_W'(WR_TC)) begin
              dly_cnt       <= '0;
              state         <= WR_BURST;
              wr_burst_req  <= 1'b1;
              wr_burst_addr <= '0;
              wr_burst_data <= '0;
              word_idx      <= '0;
              beat_cnt      <= '0;
              burst_idx     <= '0;
            end else begin
              dly_cnt <= dly_cnt + DLY_W'(1);
            end
          end

          WR_BURST: begin
            if (!wr_burst_req) begin
              // One idle cycle after each finish; address and data already loaded.
              wr_burst_req <= 1'b1;
            end else if (wr_burst_finish) begin
              wr_burst_req <= 1'b0;
              beat_cnt     <= '0;
              if (last_burst) begin
                burst_idx   <= '0;
                wr_over_led <= 1'b1;
                dly_cnt     <= '0;
                state       <= RD_WAIT;
              end else begin
                // Untaken words of a short burst are skipped: restart at the next base.
                burst_idx     <= burst_idx + BIDX_W'(1);
                wr_burst_addr <= wr_next_base;
                word_idx      <= wr_next_base;
                wr_burst_data <= DATA_WIDTH'(wr_next_base);
              end
            end else if (wr_take) begin
              beat_cnt      <= beat_cnt + BEAT_W'(1);
              word_idx      <= word_idx + ADDR_WIDTH'(1);
              wr_burst_data <= DATA_WIDTH'(word_idx + ADDR_WIDTH'(1));
            end
          end

          RD_WAIT: begin
            if (dly_cnt == DLY_W'(RD_TC)) begin
              dly_cnt       <= '0;
              state         <= RD_BURST;
              rd_burst_req  <= 1'b1;
              rd_burst_addr <= '0;
              word_idx      <= '0;
              beat_cnt      <= '0;
              burst_idx     <= '0;
            end else begin
              dly_cnt <= dly_cnt + DLY_W'(1);
            end
          end

          RD_BURST: begin
            if (!rd_burst_req) begin
              rd_burst_req <= 1'b1;
            end else begin
              if (err_add != '0) begin
                err_count    <= err_next;
                rd_error_led <= 1'b1;
              end
              if (rd_burst_finish) begin
                rd_burst_req <= 1'b0;
                beat_cnt     <= '0;
                if (last_burst) begin
                  burst_idx <= '0;
                  test_done <= 1'b1;
                  state     <= DONE;
                end else begin
                  burst_idx     <= burst_idx + BIDX_W'(1);
                  rd_burst_addr <= rd_next_base;
                  word_idx      <= rd_next_base;
                end
              end else if (rd_take) begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
                word_idx <= word_idx + ADDR_WIDTH'(1);
              end
            end
          end

          DONE: begin
            // Single run per reset or init cycle: hold all results.
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// Directed bench for ddr2_traffic_gen: a table of whole-test scenarios driven
// by a bench-side controller responder, plus hand sequences for abort and
// asynchronous reset.
module tb_ddr2_traffic_gen;

  localparam int AW  = 26;
  localparam int DW  = 32;
  localparam int WL  = 8;
  localparam int RL  = 8;
  localparam int NB  = 4;
  localparam int WD  = 20;
  localparam int RDL = 50;

  logic          sys_clk;
  logic          sys_rst_n;
  logic          init_end;
  logic          wr_burst_req;
  logic [AW-1:0] wr_burst_addr;
  logic [7:0]    wr_burst_len;
  logic          wr_burst_data_req;
  logic [DW-1:0] wr_burst_data;
  logic          wr_burst_finish;
  logic          rd_burst_req;
  logic [AW-1:0] rd_burst_addr;
  logic [7:0]    rd_burst_len;
  logic          rd_burst_data_valid;
  logic [DW-1:0] rd_burst_data;
  logic          rd_burst_finish;
  logic          init_end_led;
  logic          wr_over_led;
  logic          rd_error_led;
  logic          test_done;
  logic [15:0]   err_count;

  ddr2_traffic_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WBURST_LEN(WL), .RBURST_LEN(RL),
    .NUM_BURSTS(NB), .WR_DELAY(WD), .RD_DELAY(RDL)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end(init_end),
    .wr_burst_req(wr_burst_req), .wr_burst_addr(wr_burst_addr),
    .wr_burst_len(wr_burst_len), .wr_burst_data_req(wr_burst_data_req),
    .wr_burst_data(wr_burst_data), .wr_burst_finish(wr_burst_finish),
    .rd_burst_req(rd_burst_req), .rd_burst_addr(rd_burst_addr),
    .rd_burst_len(rd_burst_len), .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_data(rd_burst_data), .rd_burst_finish(rd_burst_finish),
    .init_end_led(init_end_led), .wr_over_led(wr_over_led),
    .rd_error_led(rd_error_led), .test_done(test_done), .err_count(err_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // One whole-test scenario: responder knobs and the expected end result.
  typedef struct packed {
    bit bp;        // write data_req toggles every other cycle
    int corrupt;   // word address whose bit 0 is flipped on read, -1 none
    int short_b;   // read burst returned short, finish with its last beat, -1 none
    int short_n;   // beats returned in that short burst
    int extra_b;   // read burst given one surplus valid beat, -1 none
    int exp_err;
    bit exp_led;
  } scen_t;

  scen_t         rows [5];
  int            tests = 0;
  int            fails = 0;
  int            cur   = -1;
  logic [DW-1:0] mem [0:63];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL [scen %0d] %s: got %0h expected %0h", cur, name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    init_end            = 1'b0;
    wr_burst_data_req   = 1'b0;
    wr_burst_finish     = 1'b0;
    rd_burst_data_valid = 1'b0;
    rd_burst_data       = '0;
    rd_burst_finish     = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  function automatic logic any_output();
    return |{wr_burst_req, wr_burst_addr, wr_burst_len, wr_burst_data,
             rd_burst_req, rd_burst_addr, rd_burst_len, init_end_led,
             wr_over_led, rd_error_led, test_done, err_count};
  endfunction

  // Raise init_end at a negedge and count edges to the first write request.
  task automatic start_and_wait();
    int cnt = 0;
    init_end = 1'b1;
    while (!wr_burst_req && cnt < 500) begin
      @(posedge sys_clk);
      #1;
      cnt++;
    end
    // 1 edge to register init_end, 1 to enter the wait state, WD counting edges.
    check("wr_req_delay", cnt, 2 + WD);
    @(negedge sys_clk);
  endtask

  // Serve n data beats of write burst b; inputs change only at negedges.
  task automatic write_beats(input int b, input bit bp, input int n);
    int  base = b * WL;
    int  i = 0;
    int  guard = 0;
    bit  t = 1'b0;
    bit  dreq;
    check("wr_addr", wr_burst_addr, base);
    check("wr_len", wr_burst_len, WL);
    while (i < n && guard < 100) begin
      check("wr_data", wr_burst_data, 32'(base + i));
      check("wr_req_held", wr_burst_req, 1);
      dreq = bp ? t : 1'b1;
      t = ~t;
      wr_burst_data_req = dreq;
      if (dreq) begin
        mem[base + i] = wr_burst_data;
        i++;
      end
      guard++;
      @(negedge sys_clk);
    end
    wr_burst_data_req = 1'b0;
  endtask

  task automatic write_finish();
    wr_burst_finish = 1'b1;
    @(negedge sys_clk);
    wr_burst_finish = 1'b0;
    check("wr_req_drop", wr_burst_req, 0);
  endtask

  task automatic run_writes(input bit bp);
    int cnt = 0;
    for (int b = 0; b < NB; b++) begin
      write_beats(b, bp, WL);
      write_finish();
      if (b < NB - 1) begin
        @(negedge sys_clk);
        check("wr_req_reassert", wr_burst_req, 1);
      end
    end
    check("wr_over_led", wr_over_led, 1);
    while (!rd_burst_req && cnt < 500) begin
      @(posedge sys_clk);
      #1;
      cnt++;
    end
    check("rd_req_delay", cnt, RDL);
    @(negedge sys_clk);
  endtask

  task automatic run_reads(input scen_t s);
    for (int b = 0; b < NB; b++) begin
      int  base = b * RL;
      int  n = (b == s.short_b) ? s.short_n : RL;
      int  total = n + ((b == s.extra_b) ? 1 : 0);
      int  w = 0;
      bit  fin_done = 1'b0;
      while (!rd_burst_req && w < 100) begin
        @(negedge sys_clk);
        w++;
      end
      check("rd_addr", rd_burst_addr, base);
      check("rd_len", rd_burst_len, RL);
      for (int i = 0; i < total; i++) begin
        rd_burst_data_valid = 1'b1;
        // A surplus beat carries the value a wrongly-advanced compare would accept.
        rd_burst_data = (i < RL) ? mem[base + i] : 32'(base + i);
        if (i < RL && (base + i) == s.corrupt) rd_burst_data[0] = ~rd_burst_data[0];
        if (i == total - 1 && b == s.short_b) begin
          rd_burst_finish = 1'b1;
          fin_done = 1'b1;
        end
        @(negedge sys_clk);
      end
      rd_burst_data_valid = 1'b0;
      if (!fin_done) begin
        rd_burst_finish = 1'b1;
        @(negedge sys_clk);
      end
      rd_burst_finish = 1'b0;
      check("rd_req_drop", rd_burst_req, 0);
    end
  endtask

  task automatic run_scenario(input scen_t s);
    start_and_wait();
    run_writes(s.bp);
    if (s.bp) begin
      for (int i = 0; i < NB * WL; i++) check("mem_fill", mem[i], 32'(i));
    end
    run_reads(s);
    @(negedge sys_clk);
    check("test_done", test_done, 1);
    check("err_count", err_count, s.exp_err);
    check("rd_error_led", rd_error_led, s.exp_led);
    check("wr_over_led_end", wr_over_led, 1);
    check("reqs_idle_end", {wr_burst_req, rd_burst_req}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    scen_t s;
    //          bp  corrupt short_b short_n extra_b err led
    rows[0] = '{1'b0, -1,    -1,     RL,     -1,     0,  1'b0};  // nominal
    rows[1] = '{1'b0, 13,    -1,     RL,     -1,     1,  1'b1};  // corrupt word 13
    rows[2] = '{1'b0, -1,     2,     6,      -1,     2,  1'b1};  // short burst 2
    rows[3] = '{1'b0, -1,    -1,     RL,      0,     1,  1'b1};  // extra beat burst 0
    rows[4] = '{1'b1, -1,    -1,     RL,     -1,     0,  1'b0};  // write backpressure

    clear_inputs();
    sys_rst_n = 1'b1;
    #2 sys_rst_n = 1'b0;
    #1 check("reset_outputs", any_output(), 0);
    repeat (3) @(negedge sys_clk);
    check("reset_held_outputs", any_output(), 0);
    sys_rst_n = 1'b1;

    for (int r = 0; r < 5; r++) begin
      cur = r;
      do_reset();
      repeat (95) @(negedge sys_clk);
      check("idle_no_req", {wr_burst_req, rd_burst_req, test_done}, 0);
      run_scenario(rows[r]);
    end

    // Abort: keep error history through DONE, drop mid write burst 1, restart.
    cur = 5;
    do_reset();
    run_scenario(rows[1]);
    init_end = 1'b0;
    @(posedge sys_clk);
    #1;
    check("abort_done_clear", test_done, 0);
    check("abort_keep_err", err_count, 1);
    check("abort_keep_led", rd_error_led, 1);
    check("abort_wr_over", wr_over_led, 0);
    check("abort_init_led", init_end_led, 0);
    @(negedge sys_clk);
    start_and_wait();
    write_beats(0, 1'b0, WL);
    write_finish();
    @(negedge sys_clk);
    write_beats(1, 1'b0, 3);
    init_end = 1'b0;
    @(posedge sys_clk);
    #1;
    check("abort_wr_req_drop", wr_burst_req, 0);
    check("abort_wr_over_mid", wr_over_led, 0);
    repeat (5) @(negedge sys_clk);
    check("abort_stays_idle", {wr_burst_req, rd_burst_req}, 0);
    s = rows[0];
    s.exp_err = 1;
    s.exp_led = 1'b1;
    run_scenario(s);

    // Asynchronous reset in the middle of a read burst.
    cur = 6;
    do_reset();
    start_and_wait();
    run_writes(1'b0);
    rd_burst_data_valid = 1'b1;
    rd_burst_data = mem[0];
    @(negedge sys_clk);
    rd_burst_data = mem[1];
    @(negedge sys_clk);
    rd_burst_data_valid = 1'b0;
    check("pre_rst_rd_req", rd_burst_req, 1);
    #2 sys_rst_n = 1'b0;
    #1 check("async_rst_outputs", any_output(), 0);
    init_end = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
